// File: rtl/hv_sram_responder_pkg.sv
// Shared constants and types for the hypervector SRAM responders.
// One responder backs each IM / ProjM SRAM of every modality.
package hv_sram_responder_pkg;

  localparam int HV_DIMENSION = 64;

  localparam int GSR_NUM_CHANNEL = 32;
  localparam int ECG_NUM_CHANNEL = 77;
  localparam int EEG_NUM_CHANNEL = 105;

  localparam int GSR_SRAM_ADDR_WIDTH =
    $clog2(GSR_NUM_CHANNEL);
  localparam int ECG_SRAM_ADDR_WIDTH =
    $clog2(ECG_NUM_CHANNEL);
  localparam int EEG_SRAM_ADDR_WIDTH =
    $clog2(EEG_NUM_CHANNEL);

  localparam int GSR_SRAM_DEPTH = GSR_NUM_CHANNEL;
  localparam int ECG_SRAM_DEPTH = ECG_NUM_CHANNEL;
  localparam int EEG_SRAM_DEPTH = EEG_NUM_CHANNEL;

  typedef logic [HV_DIMENSION-1:0] hv_t;

  // Index width for n entries, never zero.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hv_sram_array.sv
// Behavioural 1R1W synchronous array, registered read,
// read-before-write. Drop-in point for a foundry macro wrapper.
module hv_sram_array
  import hv_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [HV_DIMENSION-1:0] rdata,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [HV_DIMENSION-1:0] wdata
);

  localparam int IDX_W = ptr_w(DEPTH);

  hv_t mem_q [DEPTH];
  hv_t rdata_q;
  hv_t rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) mem_q[waddr[IDX_W-1:0]] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hv_sram_responder.sv
// Valid/ready SRAM responder: one-cycle array read feeding an
// in-order response FIFO, with credit-based request acceptance.
module hv_sram_responder
  import hv_sram_responder_pkg::*;
#(
  parameter int sram_addr_width = 5,
  parameter int depth           = 32,
  parameter int out_fifo_depth  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [sram_addr_width-1:0] sram_addr,
  input  logic                       sram_addr_valid,
  output logic                       sram_addr_ready,
  output logic [HV_DIMENSION-1:0]    sram_hvout,
  output logic                       sram_hvout_valid,
  input  logic                       sram_hvout_ready,
  input  logic                       wr_en,
  input  logic [sram_addr_width-1:0] wr_addr,
  input  logic [HV_DIMENSION-1:0]    wr_data,
  output logic                       oob_error
);

  localparam int CNT_W = $clog2(out_fifo_depth + 1);
  localparam int PTR_W = ptr_w(out_fifo_depth);
  localparam int AW1   = sram_addr_width + 1;

  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(out_fifo_depth - 1);
  localparam logic [CNT_W:0] CAP =
    (CNT_W + 1)'(out_fifo_depth);
  localparam logic [AW1-1:0] LIM = AW1'(depth);

  hv_t fifo_q [out_fifo_depth];
  hv_t rdata;
  hv_t push_data;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   used;

  logic inflight_q, inflight_d;
  logic rd_oob_q, rd_oob_d;
  logic oob_q, oob_d;
  logic accept, push, pop;
  logic rd_ok, wr_ok, we;

  always_comb begin
    used = {1'b0, count_q}
         + {{CNT_W{1'b0}}, inflight_q};
    sram_addr_ready  = used < CAP;
    sram_hvout_valid = count_q != '0;
    sram_hvout = sram_hvout_valid
               ? fifo_q[rd_ptr_q] : '0;

    rd_ok = {1'b0, sram_addr} < LIM;
    wr_ok = {1'b0, wr_addr} < LIM;
    we    = wr_en && wr_ok;

    accept = sram_addr_valid && sram_addr_ready;
    push   = inflight_q;
    pop    = sram_hvout_valid && sram_hvout_ready;

    // Out-of-range reads still occupy a slot but return zero.
    push_data = rd_oob_q ? '0 : rdata;

    inflight_d = accept;
    rd_oob_d   = accept ? !rd_ok : rd_oob_q;
    oob_d      = oob_q
               || (accept && !rd_ok)
               || (wr_en && !wr_ok);

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST)
               ? '0 : wr_ptr_q + 1'b1;
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST)
               ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      rd_oob_q   <= rd_oob_d;
      oob_q      <= oob_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_data;
  end

  assign oob_error = oob_q;

  hv_sram_array #(
    .ADDR_W (sram_addr_width),
    .DEPTH  (depth)
  ) u_array (
    .clk   (clk),
    .re    (accept),
    .raddr (sram_addr),
    .rdata (rdata),
    .we    (we),
    .waddr (wr_addr),
    .wdata (wr_data)
  );

endmodule

// File: tb/tb_hv_sram_responder.sv
// Directed bench for hv_sram_responder: latency, streaming,
// backpressure, collision, out-of-range and reset.
module tb_hv_sram_responder;
  import hv_sram_responder_pkg::*;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] sram_addr;
  logic          sram_addr_valid;
  logic          rdy, rdy10;
  hv_t           hvout, hvout10;
  logic          hv_valid, hv_valid10;
  logic          hvout_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  hv_t           wr_data;
  logic          oob, oob10;

  hv_t exp_mem [32];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  hv_sram_responder #(
    .sram_addr_width (AW),
    .depth           (32),
    .out_fifo_depth  (3)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .sram_addr        (sram_addr),
    .sram_addr_valid  (sram_addr_valid),
    .sram_addr_ready  (rdy),
    .sram_hvout       (hvout),
    .sram_hvout_valid (hv_valid),
    .sram_hvout_ready (hvout_ready),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .oob_error        (oob)
  );

  hv_sram_responder #(
    .sram_addr_width (AW),
    .depth           (10),
    .out_fifo_depth  (3)
  ) u_dut10 (
    .clk              (clk),
    .rst              (rst),
    .sram_addr        (sram_addr),
    .sram_addr_valid  (sram_addr_valid),
    .sram_addr_ready  (rdy10),
    .sram_hvout       (hvout10),
    .sram_hvout_valid (hv_valid10),
    .sram_hvout_ready (hvout_ready),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .oob_error        (oob10)
  );

  task automatic check(input string tag,
                       input hv_t obs,
                       input hv_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  function automatic hv_t pat(input int i);
    hv_t v;
    for (int b = 0; b < HV_DIMENSION / 4; b++)
      v[b*4 +: 4] = 4'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input hv_t d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < 32) exp_mem[a] = d;
  endtask

  // Back-to-back reads of base..base+n-1, ready held high.
  task automatic stream(input int base, input int n);
    hvout_ready = 1'b1;
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        sram_addr       = AW'(base + c);
        sram_addr_valid = 1'b1;
        check("stream_rdy", rdy, 1);
      end else begin
        sram_addr_valid = 1'b0;
      end
      tick();
      if (c >= 1) begin
        check("stream_vld", hv_valid, 1);
        check("stream_dat", hvout,
              exp_mem[base + c - 1]);
        if (base + c - 1 < 10)
          check("stream_dat10", hvout10,
                exp_mem[base + c - 1]);
      end
    end
    tick();
    check("stream_end", hv_valid, 0);
  endtask

  initial begin
    int   idx;
    logic acc;
    int   addrs [4];
    hv_t  x_old;
    hv_t  y_new;

    addrs = '{1, 2, 3, 4};
    y_new = 64'hDEAD_BEEF_CAFE_F00D;

    rst             = 1'b1;
    sram_addr       = '0;
    sram_addr_valid = 1'b0;
    hvout_ready     = 1'b1;
    wr_en           = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", hv_valid, 0);
    check("rst_data", hvout, 0);
    check("rst_ready", rdy, 1);
    check("rst_oob", oob, 0);

    // Basic read, two-cycle latency.
    wr(3, pat(10));
    sram_addr       = 5'd3;
    sram_addr_valid = 1'b1;
    tick();
    sram_addr_valid = 1'b0;
    check("basic_lat1", hv_valid, 0);
    tick();
    check("basic_valid", hv_valid, 1);
    check("basic_data", hvout, pat(10));
    check("basic_oob", oob, 0);
    tick();
    check("basic_drain", hv_valid, 0);

    for (int i = 0; i < 10; i++) wr(i, pat(i));
    stream(0, 8);

    // Backpressure: only three requests fit.
    hvout_ready     = 1'b0;
    sram_addr_valid = 1'b1;
    idx             = 0;
    for (int c = 0; c < 6; c++) begin
      sram_addr = AW'(addrs[idx]);
      acc       = rdy;
      tick();
      if (acc) idx++;
    end
    check("bp_accepted", hv_t'(idx), 3);
    check("bp_ready", rdy, 0);
    check("bp_head", hvout, pat(1));
    tick();
    check("bp_hold", hvout, pat(1));
    check("bp_ready_low", rdy, 0);
    hvout_ready = 1'b1;
    tick();
    check("bp_reassert", rdy, 1);
    check("bp_d2", hvout, pat(2));
    tick();
    sram_addr_valid = 1'b0;
    check("bp_d3", hvout, pat(3));
    tick();
    check("bp_d4", hvout, pat(4));
    tick();
    check("bp_drain", hv_valid, 0);

    // Same-edge write and read returns old data.
    x_old           = exp_mem[5];
    wr_en           = 1'b1;
    wr_addr         = 5'd5;
    wr_data         = y_new;
    sram_addr       = 5'd5;
    sram_addr_valid = 1'b1;
    tick();
    wr_en           = 1'b0;
    sram_addr_valid = 1'b0;
    exp_mem[5]      = y_new;
    tick();
    check("coll_old", hvout, x_old);
    tick();
    sram_addr_valid = 1'b1;
    tick();
    sram_addr_valid = 1'b0;
    tick();
    check("coll_new", hvout, y_new);
    tick();

    // Out-of-range on the depth-10 instance.
    check("oob10_pre", oob10, 0);
    sram_addr       = 5'd12;
    sram_addr_valid = 1'b1;
    tick();
    sram_addr_valid = 1'b0;
    check("oob10_set", oob10, 1);
    check("oob32_clr", oob, 0);
    tick();
    check("oob10_valid", hv_valid10, 1);
    check("oob10_zero", hvout10, 0);
    tick();
    wr(15, '1);
    check("oob10_sticky", oob10, 1);
    stream(0, 10);
    check("oob32_still", oob, 0);

    // Reset with two buffered and one in flight.
    hvout_ready     = 1'b0;
    sram_addr_valid = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      sram_addr = AW'(a);
      tick();
    end
    sram_addr_valid = 1'b0;
    check("rm_pre_valid", hv_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_valid", hv_valid, 0);
    check("rm_data", hvout, 0);
    check("rm_ready", rdy, 1);
    check("rm_oob10", oob10, 0);
    hvout_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rm_nostale", hv_valid, 0);
      check("rm_nostale10", hv_valid10, 0);
    end
    stream(2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
